// File: rtl/gray_code_pipe.sv
// gray_code_pipe
//   Per-channel Gray<->binary converter with a one-deep valid/ready output
//   register. Every channel also reports the binary-domain step from the
//   previous accepted beat and keeps a sticky flag. The flag is set when an
//   incoming Gray code differs from the previous one in more than one bit.
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous reset, active-high
//   mode       : 0 = Gray->binary, 1 = binary->Gray (sampled on accept)
//   in_valid   : input beat valid
//   in_ready   : block can accept a beat (= !out_valid || out_ready)
//   in_data    : NCH*WIDTH input, channel c at [c*WIDTH +: WIDTH]
//   out_valid  : output beat valid
//   out_ready  : downstream accepts the output beat
//   out_data   : converted code per channel
//   out_delta  : (cur_bin - prev_bin) mod 2^WIDTH per channel, 0 on a first sample
//   err_sticky : per-channel Gray step violation flag
//   err_clr    : synchronous clear of err_sticky (a coincident set wins)
module gray_code_pipe #(
    parameter int unsigned WIDTH = 5,
    parameter int unsigned NCH   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NCH*WIDTH-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NCH*WIDTH-1:0] out_data,
    output logic [NCH*WIDTH-1:0] out_delta,
    output logic [NCH-1:0]       err_sticky,
    input  logic                 err_clr
);

    logic [NCH-1:0][WIDTH-1:0] w_in;
    logic [NCH-1:0][WIDTH-1:0] w_conv;
    logic [NCH-1:0][WIDTH-1:0] w_bin;
    logic [NCH-1:0][WIDTH-1:0] w_delta;
    logic [NCH-1:0][WIDTH-1:0] w_gdiff;
    logic [NCH-1:0]            w_viol;
    logic                      w_accept;
    logic                      w_mode_chg;

    logic [NCH-1:0][WIDTH-1:0] r_prev_bin;
    logic [NCH-1:0][WIDTH-1:0] r_prev_raw;
    logic [NCH-1:0][WIDTH-1:0] r_out_data;
    logic [NCH-1:0][WIDTH-1:0] r_out_delta;
    logic [NCH-1:0]            r_ref_valid;
    logic [NCH-1:0]            r_err;
    logic                      r_mode;
    logic                      r_out_valid;

    assign w_in       = in_data;
    assign in_ready   = !r_out_valid || out_ready;
    assign w_accept   = in_valid && in_ready;
    // A mode switch makes the stored references meaningless in the new
    // domain, so the beat that switches is handled as a first sample.
    assign w_mode_chg = (mode != r_mode);

    always_comb begin
        logic v_ref;
        w_conv  = '0;
        w_bin   = '0;
        w_delta = '0;
        w_gdiff = '0;
        w_viol  = '0;
        v_ref   = 1'b0;
        for (int unsigned c = 0; c < NCH; c++) begin
            if (mode) begin
                w_conv[c] = w_in[c] ^ (w_in[c] >> 1);
                w_bin[c]  = w_in[c];
            end else begin
                // Prefix XOR from the MSB down.
                w_conv[c][WIDTH-1] = w_in[c][WIDTH-1];
                for (int unsigned i = 1; i < WIDTH; i++) begin
                    w_conv[c][WIDTH-1-i] = w_in[c][WIDTH-1-i] ^ w_conv[c][WIDTH-i];
                end
                w_bin[c] = w_conv[c];
            end
            v_ref      = r_ref_valid[c] && !w_mode_chg;
            w_delta[c] = v_ref ? (w_bin[c] - r_prev_bin[c]) : '0;
            w_gdiff[c] = w_in[c] ^ r_prev_raw[c];
            // x & (x-1) is nonzero exactly when x has two or more bits set.
            w_viol[c]  = v_ref && !mode &&
                         ((w_gdiff[c] & (w_gdiff[c] - WIDTH'(1))) != '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_delta <= '0;
            r_prev_bin  <= '0;
            r_prev_raw  <= '0;
            r_ref_valid <= '0;
            r_mode      <= 1'b0;
            r_err       <= '0;
        end else begin
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_conv;
                r_out_delta <= w_delta;
                r_prev_bin  <= w_bin;
                r_prev_raw  <= w_in;
                r_ref_valid <= '1;
                r_mode      <= mode;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            r_err <= (r_err & ~{NCH{err_clr}}) | (w_viol & {NCH{w_accept}});
        end
    end

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_delta  = r_out_delta;
    assign err_sticky = r_err;

endmodule

// File: tb/tb_gray_code_pipe.sv
module tb_gray_code_pipe;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    // WIDTH=5, NCH=1 instance
    logic       mode = 1'b0, in_valid = 1'b0, out_ready = 1'b1, err_clr = 1'b0;
    logic       in_ready, out_valid;
    logic [4:0] in_data = '0, out_data, out_delta;
    logic [0:0] err_sticky;

    // WIDTH=5, NCH=2 instance
    logic       mode2 = 1'b0, in_valid2 = 1'b0, out_ready2 = 1'b1, err_clr2 = 1'b0;
    logic       in_ready2, out_valid2;
    logic [9:0] in_data2 = '0, out_data2, out_delta2;
    logic [1:0] err_sticky2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    gray_code_pipe #(.WIDTH(5), .NCH(1)) u_dut (
        .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_delta(out_delta), .err_sticky(err_sticky),
        .err_clr(err_clr)
    );

    gray_code_pipe #(.WIDTH(5), .NCH(2)) u_dut2 (
        .clk(clk), .rst(rst), .mode(mode2), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_data(in_data2), .out_valid(out_valid2), .out_ready(out_ready2),
        .out_data(out_data2), .out_delta(out_delta2), .err_sticky(err_sticky2),
        .err_clr(err_clr2)
    );

    typedef struct {
        logic       mode;
        logic [4:0] din;
        logic [4:0] exp_data;
        logic [4:0] exp_delta;
        logic       exp_err;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One accept with out_ready=1; leaves in_valid low after the edge.
    task automatic send(input logic m, input logic [4:0] d);
        mode     = m;
        in_data  = d;
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        //          mode  din       data      delta    err
        vecs[0] = '{1'b0, 5'b00110, 5'b00100, 5'd0,  1'b0}; // first sample
        vecs[1] = '{1'b1, 5'b01011, 5'b01110, 5'd0,  1'b0}; // mode switch
        vecs[2] = '{1'b1, 5'b01100, 5'b01010, 5'd1,  1'b0};
        vecs[3] = '{1'b1, 5'b00000, 5'b00000, 5'd20, 1'b0}; // 12 -> 0
        vecs[4] = '{1'b0, 5'b10000, 5'b11111, 5'd0,  1'b0}; // mode switch, bin 31
        vecs[5] = '{1'b0, 5'b00000, 5'b00000, 5'd1,  1'b0}; // wrap 31 -> 0
        vecs[6] = '{1'b0, 5'b00001, 5'b00001, 5'd1,  1'b0};
        vecs[7] = '{1'b0, 5'b00011, 5'b00010, 5'd1,  1'b0};
        vecs[8] = '{1'b0, 5'b00000, 5'b00000, 5'd30, 1'b1}; // 2-bit Gray step
        vecs[9] = '{1'b0, 5'b00000, 5'b00000, 5'd0,  1'b1}; // sticky holds

        // Reset state
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_delta", 32'(out_delta), 32'd0);
        chk("rst_err", 32'(err_sticky), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Table: back-to-back accepts, one beat per cycle
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'd1);
            send(vecs[i].mode, vecs[i].din);
            chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("v%0d_out_data", i), 32'(out_data), 32'(vecs[i].exp_data));
            chk($sformatf("v%0d_out_delta", i), 32'(out_delta), 32'(vecs[i].exp_delta));
            chk($sformatf("v%0d_err", i), 32'(err_sticky), 32'(vecs[i].exp_err));
        end

        // err_clr alone clears; beat consumed with no accept drops out_valid
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("clr_err", 32'(err_sticky), 32'd0);
        chk("consume_out_valid", 32'(out_valid), 32'd0);

        // err_clr coincident with a violation: set wins (00000 -> 00011)
        err_clr = 1'b1;
        send(1'b0, 5'b00011);
        err_clr = 1'b0;
        chk("clr_vs_set_err", 32'(err_sticky), 32'd1);
        chk("clr_vs_set_data", 32'(out_data), 32'd2);
        chk("clr_vs_set_delta", 32'(out_delta), 32'd2);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("clr2_err", 32'(err_sticky), 32'd0);

        // Backpressure: 00011 -> 00010 (bin 3), then hold 00110 pending
        send(1'b0, 5'b00010);
        chk("bp_first_data", 32'(out_data), 32'd3);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 5'b00110;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("bp%0d_in_ready", k), 32'(in_ready), 32'd0);
            chk($sformatf("bp%0d_out_valid", k), 32'(out_valid), 32'd1);
            chk($sformatf("bp%0d_out_data", k), 32'(out_data), 32'd3);
            chk($sformatf("bp%0d_out_delta", k), 32'(out_delta), 32'd1);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("bp_next_data", 32'(out_data), 32'd4);
        chk("bp_next_delta", 32'(out_delta), 32'd1);
        chk("bp_next_err", 32'(err_sticky), 32'd0);
        tick();
        chk("bp_drain_valid", 32'(out_valid), 32'd0);

        // Reset mid-beat: 00110 -> 00000 is a violation, then reset asynchronously
        send(1'b0, 5'b00000);
        chk("pre_rst_err", 32'(err_sticky), 32'd1);
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_err", 32'(err_sticky), 32'd0);
        chk("async_rst_data", 32'(out_data), 32'd0);
        chk("async_rst_in_ready", 32'(in_ready), 32'd1);
        tick();
        rst = 1'b0;
        // Large Gray jump from stored 0, but a first sample: no delta, no check
        send(1'b0, 5'b01111);
        chk("post_rst_data", 32'(out_data), 32'd10);
        chk("post_rst_delta", 32'(out_delta), 32'd0);
        chk("post_rst_err", 32'(err_sticky), 32'd0);

        // NCH=2: violation on channel 1 only
        mode2 = 1'b0;
        in_data2 = {5'b00000, 5'b00000};
        in_valid2 = 1'b1;
        tick();
        in_data2 = {5'b00011, 5'b00001};
        tick();
        in_valid2 = 1'b0;
        chk("nch2_err", 32'(err_sticky2), 32'd2);
        chk("nch2_data", 32'(out_data2), 32'({5'd2, 5'd1}));
        chk("nch2_delta", 32'(out_delta2), 32'({5'd2, 5'd1}));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gray_code_pipe.md
GRAY_CODE_PIPE -- requirements
Module: gray_code_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 5, giving the code width per channel in bits (WIDTH >= 2).
REQ-002 The block SHALL have parameter NCH, default 1, giving the number of independent channels (NCH >= 1).
REQ-003 The block SHALL use one clock and an asynchronous active-high reset, with ports as follows.
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous reset, active-high
- mode  in  1  0 = Gray->binary, 1 = binary->Gray; sampled on input acceptance
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- in_data  in  NCH*WIDTH  channel c at bits [c*WIDTH +: WIDTH]
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts the beat
- out_data  out  NCH*WIDTH  converted code per channel
- out_delta  out  NCH*WIDTH  binary-domain step per channel since the previous accepted beat, mod 2^WIDTH
- err_sticky  out  NCH  Gray step violation flag per channel, sticky
- err_clr  in  1  synchronous clear of all err_sticky bits

Function
REQ-004 An input beat SHALL be accepted on a rising clk when in_valid and in_ready are both 1.
REQ-005 An output beat SHALL be consumed on a rising clk when out_valid and out_ready are both 1.
REQ-006 in_ready SHALL equal (!out_valid || out_ready), giving a combinational path from out_ready to in_ready.
REQ-007 Latency SHALL be 1 cycle: a beat accepted at edge N SHALL appear on out_valid/out_data after edge N.
REQ-008 With back-to-back acceptance and out_ready held at 1, throughput SHALL be one beat per cycle.
REQ-009 out_data and out_delta SHALL hold stable while out_valid=1 and out_ready=0.
REQ-010 out_valid SHALL clear after a consume edge with no simultaneous accept.
REQ-011 Conversion in mode 0 (Gray->binary) SHALL follow these rules.
- b[W-1] = g[W-1]
- b[i] = g[i] ^ b[i+1] for i = W-2 down to 0
- out_data = b
REQ-012 Conversion in mode 1 (binary->Gray) SHALL be out_data = in ^ (in >> 1).
REQ-013 The block SHALL compute the binary value per channel as follows.
- mode 0: the converted result
- mode 1: the input itself
REQ-014 Each channel SHALL store, on every accept, the last accepted binary value, the last raw input, and a ref_valid bit.
REQ-015 out_delta SHALL be (cur_bin - prev_bin) mod 2^WIDTH, with wrap-around.
- example: 31 -> 0 gives delta 1
REQ-016 When ref_valid=0, out_delta SHALL be 0 and no step check SHALL occur; the accept then sets ref_valid.
REQ-017 ref_valid SHALL clear for all channels when a beat is accepted with mode different from the mode of the previous accepted beat.
- that beat is treated as a first sample
REQ-018 The step check SHALL run in mode 0 with ref_valid=1: if popcount(in_gray ^ prev_gray) > 1, err_sticky[c] SHALL be set at the accept edge.
- a Hamming distance of 0 or 1 is legal
REQ-019 The step check SHALL be disabled in mode 1.
REQ-020 err_sticky[c] SHALL hold until err_clr or reset; if err_clr and a new violation coincide in the same cycle, the set SHALL win.
REQ-021 Channels SHALL be fully independent, sharing only the handshake and mode.

Reset
REQ-022 Asserting rst SHALL immediately force the following, regardless of clk.
- out_valid = 0
- out_data = 0, out_delta = 0
- err_sticky = 0
- all ref_valid = 0
- stored previous values = 0
- stored mode = 0
REQ-023 in_ready SHALL read 1 during and after reset, per REQ-006 with out_valid = 0.
REQ-024 Reset mid-operation SHALL discard any pending output beat with no partial transfer.
- the first accept after release is a first sample

Verification (WIDTH=5, NCH=1 unless noted)
REQ-025 Mode 0, in_data=5'b00110 accepted, out_ready=1 -> next cycle out_valid=1, out_data=5'b00100, out_delta=0.
REQ-026 Mode 1, in_data=5'b01011 -> out_data=5'b01110; then in_data=5'b01100 -> out_data=5'b01010, out_delta=5'd1.
REQ-027 Backpressure: hold out_ready=0 for 3 cycles with out_valid=1 and in_valid=1 -> in_ready=0, and out_data/out_delta stay unchanged with no beat lost.
- on raising out_ready, the pending input is accepted the same edge
REQ-028 Step error: mode 0 accept gray 5'b00000, then 5'b00011 -> err_sticky=1; pulse err_clr alone -> err_sticky=0.
- err_clr coincident with a new violation -> err_sticky stays 1
REQ-029 Wrap: mode 0 gray 5'b10000 (binary 31), then 5'b00000 -> out_data=0, out_delta=5'd1, err_sticky=0.
REQ-030 Reset mid-beat: assert rst asynchronously while out_valid=1 -> out_valid=0 and err_sticky=0 immediately.
- next accepted beat gives out_delta=0 with no step check
- NCH=2 variant: error on channel 1 only sets err_sticky=2'b10
